conv_stream_tx: RTL

CONV_STREAM_TX -- requirements
Module: conv_stream_tx

---
 rtl/conv_stream_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/conv_stream_tx.sv
// conv_stream_tx: streams W (K*K words), B (1 word) and X (R*C words) from a
// source memory toward the convolution input interface, or X alone when the
// command does not request new weights.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   CMD_VALID/CMD_READY        command handshake; CMD_READY is high only when idle
//   CMD_K, CMD_NEW_W           kernel size and "send W and B first" flag
//   MEM_RD_EN/MEM_ADDR         read strobe and address toward the source memory
//   MEM_DATA                   read data, valid one cycle after MEM_RD_EN
//   OUT_TDATA/TVALID/TREADY    output stream
//   OUT_TUSER                  {K, new_W flag} travelling with each beat
//   DONE                       one-cycle pulse after the last beat is accepted
module conv_stream_tx #(
  parameter int unsigned INW  = 18,
  parameter int unsigned R    = 8,
  parameter int unsigned C    = 8,
  parameter int unsigned MAXK = 5,
  localparam int unsigned K_BITS = $clog2(MAXK + 1),
  localparam int unsigned AW     = $clog2(MAXK * MAXK + 1 + R * C)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [K_BITS-1:0] CMD_K,
  input  logic              CMD_NEW_W,
  output logic              MEM_RD_EN,
  output logic [AW-1:0]     MEM_ADDR,
  input  logic [INW-1:0]    MEM_DATA,
  output logic [INW-1:0]    OUT_TDATA,
  output logic              OUT_TVALID,
  output logic [K_BITS:0]   OUT_TUSER,
  input  logic              OUT_TREADY,
  output logic              DONE
);

  localparam logic [AW-1:0] BaseB = AW'(MAXK * MAXK);
  localparam logic [AW-1:0] BaseX = AW'(MAXK * MAXK + 1);
  localparam logic [AW-1:0] LastX = AW'(MAXK * MAXK + R * C);

  typedef enum logic [2:0] {StIdle, StRdW, StRdB, StRdX, StDrain} state_e;

  state_e            state_q;
  logic [K_BITS-1:0] k_q;
  logic [AW-1:0]     addr_q;
  logic              done_q;
  logic              inflight_q;      // a read was issued last cycle
  logic              inflight_tag_q;  // that read belongs to W/B (1) or X (0)

  // Two-entry output buffer; the tag is stored next to the data.
  logic [INW-1:0]    buf_data_q [2];
  logic [K_BITS:0]   buf_user_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;

  logic              pop;
  logic              in_rd;
  logic              rd;
  logic [2:0]        level;
  logic [AW-1:0]     k_ext;
  logic [AW-1:0]     w_last;

  assign k_ext  = AW'(k_q);
  assign w_last = k_ext * k_ext - AW'(1);

  always_comb begin
    pop   = (occ_q != 2'd0) && OUT_TREADY;
    in_rd = (state_q == StRdW) || (state_q == StRdB) || (state_q == StRdX);
    // Committed buffer usage once this cycle's pop is taken into account;
    // a new read is only safe while it stays below the buffer depth.
    level = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    rd    = in_rd && (level < 3'd2);
  end

  assign CMD_READY  = (state_q == StIdle);
  assign MEM_RD_EN  = rd;
  assign MEM_ADDR   = addr_q;
  assign OUT_TVALID = (occ_q != 2'd0);
  assign OUT_TDATA  = buf_data_q[rd_ptr_q];
  assign OUT_TUSER  = buf_user_q[rd_ptr_q];
  assign DONE       = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      k_q            <= '0;
      addr_q         <= '0;
      done_q         <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      inflight_q     <= rd;
      inflight_tag_q <= (state_q != StRdX);
      unique case (state_q)
        StIdle: begin
          if (CMD_VALID) begin
            k_q <= CMD_K;
            if (CMD_NEW_W) begin
              state_q <= StRdW;
              addr_q  <= '0;
            end else begin
              state_q <= StRdX;
              addr_q  <= BaseX;
            end
          end
        end
        StRdW: begin
          if (rd) begin
            if (addr_q == w_last) begin
              state_q <= StRdB;
              addr_q  <= BaseB;
            end else begin
              addr_q <= addr_q + AW'(1);
            end
          end
        end
        StRdB: begin
          if (rd) begin
            state_q <= StRdX;
            addr_q  <= BaseX;
          end
        end
        StRdX: begin
          if (rd) begin
            if (addr_q == LastX) begin
              state_q <= StDrain;
              addr_q  <= '0;
            end else begin
              addr_q <= addr_q + AW'(1);
            end
          end
        end
        StDrain: begin
          // Leave on the edge that accepts the final beat so DONE lines up
          // with the return to idle.
          if (!inflight_q && ((occ_q - 2'(pop)) == 2'd0)) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_user_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (inflight_q) begin
        buf_data_q[wr_ptr_q] <= MEM_DATA;
        buf_user_q[wr_ptr_q] <= {k_q, inflight_tag_q};
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + 2'(inflight_q) - 2'(pop);
    end
  end

endmodule
